// File: rtl/sram_req_arbiter_pkg.sv
// Shared owner codes, arbiter state encodings and memory size codes for the
// sram-like request arbiter.
package sram_req_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_I = 2'd1,
    ARB_HOLD_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// In-order owner queue: one {discard, owner} entry per accepted address phase,
// popped as responses come back in request order.
module arb_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_owner,
  input  logic push_discard,
  input  logic pop,
  input  logic clear_inst_discard,
  output logic head_owner,
  output logic head_discard,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] owner_q;
  logic [DEPTH-1:0] discard_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= '0;
      discard_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      // Marking free slots too is harmless: a push overwrites both fields.
      if (clear_inst_discard) discard_q <= discard_q | ~owner_q;
      if (push) begin
        owner_q[wr_ptr]   <= push_owner;
        discard_q[wr_ptr] <= push_discard;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_owner   = owner_q[rd_ptr];
  assign head_discard = discard_q[rd_ptr];
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between fetch and data requesters, routing
// responses by an in-order owner queue. ARB_ROUND_ROBIN_EN enables round-robin.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_state
);

  // Handshake: a requester holds req and payload stable until its addr_ok;
  // mem_req/mem_* follow the same rule towards the bridge (held until
  // mem_addr_ok). data_ok is a one-cycle pulse with no back-pressure.

  arb_state_e state_q, state_d;
  logic grant_valid, grant_owner;
  logic push, pop;
  logic head_owner, head_discard, fifo_full, fifo_empty;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;
  always_ff @(posedge clk) begin
    if (reset)     last_grant <= OWNER_INST;
    else if (push) last_grant <= grant_owner;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:
        if (grant_valid && !mem_addr_ok)
          state_d = (grant_owner == OWNER_DATA) ? ARB_HOLD_D : ARB_HOLD_I;
      ARB_HOLD_I, ARB_HOLD_D:
        if (mem_addr_ok) state_d = ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    case (state_q)
      ARB_IDLE:
        if (!reset && !fifo_full) begin
          if (data_req && inst_req) begin
            grant_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            grant_owner = (last_grant == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
            grant_owner = OWNER_DATA;
`endif
          end else if (data_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_DATA;
          end else if (inst_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_INST;
          end
        end
      ARB_HOLD_I: begin
        grant_valid = !reset;
        grant_owner = OWNER_INST;
      end
      ARB_HOLD_D: begin
        grant_valid = !reset;
        grant_owner = OWNER_DATA;
      end
      default: grant_valid = 1'b0;
    endcase

    mem_req   = grant_valid;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (grant_valid && grant_owner == OWNER_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_valid) begin
      mem_size  = MEM_SIZE_WORD;
      mem_addr  = inst_addr;
    end
  end

  assign push         = mem_req && mem_addr_ok;
  assign pop          = mem_data_ok && !fifo_empty && !reset;
  assign inst_addr_ok = push && (grant_owner == OWNER_INST);
  assign data_addr_ok = push && (grant_owner == OWNER_DATA);
  assign inst_data_ok = pop && (head_owner == OWNER_INST) && !head_discard;
  assign data_data_ok = pop && (head_owner == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign arb_state    = state_q;

  arb_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .clk                (clk),
    .reset              (reset),
    .push               (push),
    .push_owner         (grant_owner),
    .push_discard       (inst_cancel && (grant_owner == OWNER_INST)),
    .pop                (pop),
    .clear_inst_discard (inst_cancel),
    .head_owner         (head_owner),
    .head_discard       (head_discard),
    .full               (fifo_full),
    .empty              (fifo_empty)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bridge protocol error; it is ignored.
  always_ff @(posedge clk) begin
    if (!reset && mem_data_ok) assert (!fifo_empty);
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: fetch, contention, hold lock, full
// queue, cancel and mid-operation reset.
module tb_sram_req_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;
`else
  localparam logic RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size, arb_state;
  logic [3:0]  mem_wstrb;

  int tests_run = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_cancel(inst_cancel),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .arb_state(arb_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    @(negedge clk);
    inst_req = 0; data_req = 0; inst_cancel = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic fetch(input logic [31:0] addr, input string tag);
    @(negedge clk);
    inst_req = 1; data_req = 0; inst_addr = addr; mem_addr_ok = 1; mem_data_ok = 0;
    #1 chk(tag, inst_addr_ok, 1);
  endtask

  task automatic pop_resp(input logic [31:0] rd, input logic exp_i, input logic exp_d,
                          input string tag);
    @(negedge clk);
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = rd;
    #1;
    chk({tag, "_inst_data_ok"}, inst_data_ok, exp_i);
    chk({tag, "_data_data_ok"}, data_data_ok, exp_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; inst_req = 0; inst_cancel = 0; data_req = 0; data_wr = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_size = 0; data_wstrb = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_state", arb_state, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);

    // single fetch, response two cycles after the address phase
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
    #1;
    chk("f1_mem_req", mem_req, 1);
    chk("f1_mem_addr", mem_addr, 32'h1c000000);
    chk("f1_mem_size", mem_size, 2);
    chk("f1_mem_wstrb", mem_wstrb, 0);
    chk("f1_inst_addr_ok", inst_addr_ok, 1);
    chk("f1_data_addr_ok", data_addr_ok, 0);
    quiet();
    #1 chk("f1_idle_mem_req", mem_req, 0);
    pop_resp(32'h02800c0c, 1, 0, "f1_resp");
    chk("f1_rdata", inst_rdata, 32'h02800c0c);
    quiet();
    #1 chk("f1_pulse_end", inst_data_ok, 0);

    // contention: data store wins, fetch follows next cycle
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h1c008000; data_wdata = 32'hdeadbeef; mem_addr_ok = 1;
    #1;
    chk("c_data_addr_ok", data_addr_ok, 1);
    chk("c_inst_addr_ok", inst_addr_ok, 0);
    chk("c_mem_wr", mem_wr, 1);
    chk("c_mem_addr", mem_addr, 32'h1c008000);
    chk("c_mem_wstrb", mem_wstrb, 4'hF);
    chk("c_mem_wdata", mem_wdata, 32'hdeadbeef);
    @(negedge clk);
    data_req = 0;
    #1;
    chk("c2_inst_addr_ok", inst_addr_ok, 1);
    chk("c2_mem_addr", mem_addr, 32'h1c000004);
    chk("c2_mem_wr", mem_wr, 0);
    pop_resp(32'h0, 0, 1, "c_resp_d");
    pop_resp(32'haabbccdd, 1, 0, "c_resp_i");

    // after a lone data grant both request: round-robin favours fetch
    @(negedge clk);
    mem_data_ok = 0; data_req = 1; data_wr = 0; data_wstrb = 0;
    data_addr = 32'h1c008010; mem_addr_ok = 1;
    #1 chk("rr0_data_addr_ok", data_addr_ok, 1);
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h1c000008; data_addr = 32'h1c008014;
    #1;
    chk("rr1_inst_addr_ok", inst_addr_ok, RR);
    chk("rr1_data_addr_ok", data_addr_ok, !RR);
    @(negedge clk);
    if (RR) inst_req = 0;
    else data_req = 0;
    #1;
    chk("rr2_inst_addr_ok", inst_addr_ok, !RR);
    chk("rr2_data_addr_ok", data_addr_ok, RR);
    pop_resp(32'h1, 0, 1, "rr_resp0");
    pop_resp(32'h2, RR, !RR, "rr_resp1");
    pop_resp(32'h3, !RR, RR, "rr_resp2");

    // hold lock: fetch address phase stalls three cycles while data asks
    @(negedge clk);
    mem_data_ok = 0; mem_addr_ok = 0; inst_req = 1; inst_addr = 32'h1c000004;
    #1;
    chk("h0_mem_addr", mem_addr, 32'h1c000004);
    chk("h0_inst_addr_ok", inst_addr_ok, 0);
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h1c008000;
      #1;
      chk("h_state", arb_state, 1);
      chk("h_mem_addr", mem_addr, 32'h1c000004);
      chk("h_data_addr_ok", data_addr_ok, 0);
    end
    @(negedge clk);
    mem_addr_ok = 1;
    #1;
    chk("h3_inst_addr_ok", inst_addr_ok, 1);
    chk("h3_data_addr_ok", data_addr_ok, 0);
    chk("h3_mem_addr", mem_addr, 32'h1c000004);
    @(negedge clk);
    inst_req = 0;
    #1;
    chk("h4_state", arb_state, 0);
    chk("h4_data_addr_ok", data_addr_ok, 1);
    chk("h4_mem_addr", mem_addr, 32'h1c008000);
    pop_resp(32'h4, 1, 0, "h_resp_i");
    pop_resp(32'h5, 0, 1, "h_resp_d");

    // full queue, then push and pop in the same cycle
    for (int k = 0; k < 4; k++) fetch(32'h1c000200 + 32'(k * 4), "full_acc");
    @(negedge clk);
    inst_addr = 32'h1c000210;
    #1;
    chk("full_mem_req", mem_req, 0);
    chk("full_inst_addr_ok", inst_addr_ok, 0);
    @(negedge clk);
    mem_data_ok = 1; mem_rdata = 32'h10;
    #1;
    chk("full_pop_inst_data_ok", inst_data_ok, 1);
    chk("full_pop_mem_req", mem_req, 0);
    @(negedge clk);
    mem_rdata = 32'h11;
    #1;
    chk("pp_inst_addr_ok", inst_addr_ok, 1);
    chk("pp_inst_data_ok", inst_data_ok, 1);
    @(negedge clk);
    mem_data_ok = 0; inst_addr = 32'h1c000214;
    #1 chk("pp_refill_addr_ok", inst_addr_ok, 1);
    @(negedge clk);
    inst_addr = 32'h1c000218;
    #1 chk("pp_full_again", mem_req, 0);
    for (int k = 0; k < 4; k++) pop_resp(32'h20 + 32'(k), 1, 0, "full_drain");

    // cancel: two fetches and a load outstanding, cancel with a fetch push
    fetch(32'h1c000020, "cx_f0");
    fetch(32'h1c000024, "cx_f1");
    @(negedge clk);
    inst_req = 0; data_req = 1; data_wr = 0; data_addr = 32'h1c008020;
    #1 chk("cx_data_addr_ok", data_addr_ok, 1);
    @(negedge clk);
    data_req = 0; inst_req = 1; inst_addr = 32'h1c000028; inst_cancel = 1;
    #1 chk("cx_push_addr_ok", inst_addr_ok, 1);
    quiet();
    pop_resp(32'h30, 0, 0, "cx_pop0");
    pop_resp(32'h31, 0, 0, "cx_pop1");
    pop_resp(32'h32, 0, 1, "cx_pop_d");
    pop_resp(32'h33, 0, 0, "cx_pop2");
    fetch(32'h1c000100, "cx_new");
    pop_resp(32'h0340000c, 1, 0, "cx_new_resp");
    chk("cx_new_rdata", inst_rdata, 32'h0340000c);

    // reset with three entries outstanding and a fetch held in the lock
    for (int k = 0; k < 3; k++) fetch(32'h1c000300 + 32'(k * 4), "rs_acc");
    @(negedge clk);
    inst_addr = 32'h1c00030c; mem_addr_ok = 0;
    @(negedge clk);
    #1 chk("rs_hold_state", arb_state, 1);
    reset = 1; inst_req = 0;
    @(negedge clk);
    reset = 0;
    #1;
    chk("rs_mem_req", mem_req, 0);
    chk("rs_state", arb_state, 0);
    chk("rs_mem_addr", mem_addr, 0);
    chk("rs_inst_data_ok", inst_data_ok, 0);
    for (int k = 0; k < 4; k++) fetch(32'h1c000400 + 32'(k * 4), "rs_empty_acc");
    @(negedge clk);
    #1 chk("rs_full_after_4", mem_req, 0);
    quiet();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
